hdmi_packet_scheduler: RTL and testbench
========================================

# hdmi_packet_scheduler

Per-slot arbiter for the HDMI data-island packet path. At each packet slot it picks which generator drives the packet mux: null, audio clock regeneration (ACR), audio sample, AVI InfoFrame, audio InfoFrame or SPD InfoFrame. It holds per-frame InfoFrame pending flags, an SPD frame divider and an anti-starvation counter, and it acknowledges consumed audio samples. It sits between the video timing generator and the packet mux that feeds the TERC4 encoder.

## Interface
- AUDIO_ENABLE, 1: when 0, `acr_req` and `audio_req` are ignored and the audio InfoFrame is never set pending.
- SPD_DIVIDER, 8: SPD InfoFrame is sent once every SPD_DIVIDER frames. Legal range 1..255.
- MAX_DEFER, 4: number of consecutive slots a pending InfoFrame may lose to audio before it is promoted above audio. Legal range 1..15.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- acr_req  in  1  one-cycle pulse from the CTS/N timer.
- audio_req  in  1  level; audio sample buffer non-empty.
- slot_start  in  1  one-cycle pulse at the start of a packet slot (every 32 clocks in a data island).
- packet_type  out  3  selected source: 0 null, 1 ACR, 2 audio sample, 3 AVI, 4 audio InfoFrame, 5 SPD.
- packet_grant  out  1  one-cycle pulse; `packet_type` has been updated.
- audio_ack  out  1  one-cycle pulse with a grant of type 2; pops one sample.

## Operation
- Pending flags (registered): `acr_p`, `avi_p`, `aif_p`, `spd_p`.
  - `acr_req` sets `acr_p` (only when AUDIO_ENABLE=1).
  - `frame_start` sets `avi_p`, and sets `aif_p` when AUDIO_ENABLE=1.
  - `frame_start` sets `spd_p` only when `frame_cnt`==0.
  - `frame_cnt` increments on every `frame_start` and wraps from SPD_DIVIDER-1 to 0.
- Arbitration on `slot_start` uses the registered flags and the current `audio_req`. The first eligible source wins, in this order:
  1. ACR
  2. InfoFrame, but only when `defer_cnt` ≥ MAX_DEFER
  3. audio sample
  4. AVI
  5. audio InfoFrame
  6. SPD
  7. null
- The promoted InfoFrame in rank 2 is the highest pending of AVI, audio InfoFrame, SPD.
- A grant clears the granted pending flag. A set event in the same cycle as a clear wins: the flag stays 1.
- `defer_cnt` (4 bits, saturating at 15) updates on each `slot_start`:
  - increments when any InfoFrame flag is pending and ACR or audio is granted;
  - clears to 0 when an InfoFrame is granted, or when no InfoFrame flag is pending;
  - otherwise holds.
- Null is granted when nothing is eligible. `packet_grant` still pulses in that case.

## Timing
- Reset values: `packet_type`=0, `packet_grant`=0, `audio_ack`=0, all pending flags 0, `frame_cnt`=0, `defer_cnt`=0.
- Reset is asynchronous. Asserting `reset_n` mid-slot drops all pending requests immediately.
- Latency: `slot_start` in cycle t produces `packet_type`, `packet_grant` and `audio_ack` in cycle t+1. Pending flags and `defer_cnt` also update at t+1.
- `packet_type` holds its value until the next grant.
- `frame_start` or `acr_req` coincident with `slot_start`: the new request is not eligible in that slot. It is eligible from the next slot.
- `audio_req` is sampled in the `slot_start` cycle. The source must deassert it within 1 cycle of its last `audio_ack`.
- `slot_start` pulses closer than 2 cycles apart are illegal. Behaviour in that case is undefined; the bench asserts against it.
- Two `acr_req` pulses before ACR is granted merge into one ACR packet.

## Test plan
- Reset: hold `reset_n`=0 with all inputs toggling → all outputs 0. Release `reset_n`, then 1 `slot_start` → `packet_type`=0 and `packet_grant`=1 at t+1.
- Frame sequence: `frame_start`, `audio_req`=0, then 4 slots → types 3, 4, 5, 0. Next `frame_start` plus 3 slots → 3, 4, 0 (SPD suppressed, `frame_cnt`=1).
- Starvation: `audio_req`=1 held, `frame_start`, then 6 slots with MAX_DEFER=4 → 2, 2, 2, 2, 3, 2. `audio_ack` pulses exactly 5 times.
- ACR priority: `acr_req` pulse and `audio_req`=1, then 2 slots → 1 then 2. With 2 `acr_req` pulses before the slot → exactly one type-1 grant.
- Set/clear collision: `frame_start` in the cycle after the `slot_start` whose grant is AVI → the next slot with `audio_req`=0 grants 3 again.
- Reset mid-operation: `reset_n` low with `avi_p`, `acr_p` set and `audio_req`=0 → after release, the next slot grants 0. A full frame then re-sends SPD (`frame_cnt` restarts at 0).

Source files
------------

// File: rtl/hdmi_packet_scheduler.sv
// Per-slot packet source arbiter for the HDMI data-island path: tracks pending
// InfoFrames, ACR and audio, and picks one packet type per slot.
module hdmi_packet_scheduler #(
  parameter bit          AUDIO_ENABLE = 1'b1,
  parameter int unsigned SPD_DIVIDER  = 8,
  parameter int unsigned MAX_DEFER    = 4
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       acr_req,
  input  logic       audio_req,
  input  logic       slot_start,
  output logic [2:0] packet_type,
  output logic       packet_grant,
  output logic       audio_ack
);

  typedef enum logic [2:0] {
    PKT_NULL  = 3'd0,
    PKT_ACR   = 3'd1,
    PKT_AUDIO = 3'd2,
    PKT_AVI   = 3'd3,
    PKT_AIF   = 3'd4,
    PKT_SPD   = 3'd5
  } pkt_t;

  localparam logic [7:0] FRAME_LAST = 8'(SPD_DIVIDER - 1);
  localparam logic [3:0] DEFER_LIM  = 4'(MAX_DEFER);

  logic       acr_p, avi_p, aif_p, spd_p;
  logic [7:0] frame_cnt;
  logic [3:0] defer_cnt, defer_next;

  logic       if_pending, audio_ok, promote;
  pkt_t       if_sel, grant_sel;
  logic       clr_acr, clr_avi, clr_aif, clr_spd;
  logic       set_acr, set_aif, set_spd;

  // NOTE: every always_comb output gets a default first so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    if_pending = avi_p | aif_p | spd_p;
    audio_ok   = AUDIO_ENABLE & audio_req;
    promote    = if_pending && (defer_cnt >= DEFER_LIM);

    if_sel = PKT_NULL;
    if (avi_p)      if_sel = PKT_AVI;
    else if (aif_p) if_sel = PKT_AIF;
    else if (spd_p) if_sel = PKT_SPD;

    // Below audio, the InfoFrame order matches the promoted order, so the
    // same pick (or null) serves ranks 4..7.
    grant_sel = if_sel;
    if (acr_p)         grant_sel = PKT_ACR;
    else if (promote)  grant_sel = if_sel;
    else if (audio_ok) grant_sel = PKT_AUDIO;
  end

  always_comb begin
    defer_next = defer_cnt;
    if (if_pending && (grant_sel == PKT_ACR || grant_sel == PKT_AUDIO)) begin
      if (defer_cnt != 4'hF) defer_next = defer_cnt + 4'd1;
    end else if (!if_pending || grant_sel == PKT_AVI || grant_sel == PKT_AIF ||
                 grant_sel == PKT_SPD) begin
      defer_next = 4'd0;
    end
  end

  always_comb begin
    clr_acr = slot_start && (grant_sel == PKT_ACR);
    clr_avi = slot_start && (grant_sel == PKT_AVI);
    clr_aif = slot_start && (grant_sel == PKT_AIF);
    clr_spd = slot_start && (grant_sel == PKT_SPD);
    set_acr = AUDIO_ENABLE & acr_req;
    set_aif = AUDIO_ENABLE & frame_start;
    set_spd = frame_start && (frame_cnt == 8'd0);
  end

  // NOTE: state uses non-blocking assignments only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_p        <= 1'b0;
      avi_p        <= 1'b0;
      aif_p        <= 1'b0;
      spd_p        <= 1'b0;
      frame_cnt    <= 8'd0;
      defer_cnt    <= 4'd0;
      packet_type  <= PKT_NULL;
      packet_grant <= 1'b0;
      audio_ack    <= 1'b0;
    end else begin
      // A set in the same cycle as a grant-clear keeps the flag high.
      acr_p <= (acr_p & ~clr_acr) | set_acr;
      avi_p <= (avi_p & ~clr_avi) | frame_start;
      aif_p <= (aif_p & ~clr_aif) | set_aif;
      spd_p <= (spd_p & ~clr_spd) | set_spd;

      if (frame_start) frame_cnt <= (frame_cnt >= FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;

      packet_grant <= slot_start;
      audio_ack    <= slot_start && (grant_sel == PKT_AUDIO);
      if (slot_start) begin
        packet_type <= grant_sel;
        defer_cnt   <= defer_next;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Bench for hdmi_packet_scheduler: directed scenarios with fixed expected grant
// sequences, then randomized traffic against a behavioural priority model.
module tb_hdmi_packet_scheduler;

  localparam bit AE   = 1'b1;
  localparam int DIV  = 8;
  localparam int MAXD = 4;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic       frame_start, acr_req, audio_req, slot_start;
  logic [2:0] packet_type;
  logic       packet_grant, audio_ack;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] seen[$];
  int         ack_seen;

  // Reference model state
  bit         m_acr;
  bit         m_if[3:5];
  int         m_fcnt, m_defer;
  logic [2:0] m_type;
  bit         m_grant, m_ack;

  hdmi_packet_scheduler #(
    .AUDIO_ENABLE(AE),
    .SPD_DIVIDER (DIV),
    .MAX_DEFER   (MAXD)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .acr_req     (acr_req),
    .audio_req   (audio_req),
    .slot_start  (slot_start),
    .packet_type (packet_type),
    .packet_grant(packet_grant),
    .audio_ack   (audio_ack)
  );

  always #5 clk_pixel = ~clk_pixel;

  int slot_gap = 100;
  always @(posedge clk_pixel) begin
    if (reset_n && slot_start) begin
      if (slot_gap < 2) $error("slot_start pulses closer than 2 cycles");
      slot_gap = 1;
    end else if (slot_gap < 100) begin
      slot_gap = slot_gap + 1;
    end
  end

  task automatic model_reset();
    m_acr = 0;
    for (int k = 3; k <= 5; k++) m_if[k] = 0;
    m_fcnt = 0; m_defer = 0; m_type = 3'd0; m_grant = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit fs, input bit acr, input bit aud, input bit slot);
    int g, top_if;
    bit any_if;
    if (slot) begin
      any_if = m_if[3] | m_if[4] | m_if[5];
      top_if = 0;
      for (int k = 5; k >= 3; k--) if (m_if[k]) top_if = k;
      if (m_acr)                          g = 1;
      else if (any_if && m_defer >= MAXD) g = top_if;
      else if (AE && aud)                 g = 2;
      else                                g = top_if;
      m_type  = 3'(g);
      m_grant = 1;
      m_ack   = (g == 2);
      if (g == 1) m_acr = 0;
      if (g >= 3) m_if[g] = 0;
      if (any_if && (g == 1 || g == 2)) m_defer = (m_defer >= 15) ? 15 : m_defer + 1;
      else if (!any_if || g >= 3)       m_defer = 0;
    end else begin
      m_grant = 0;
      m_ack   = 0;
    end
    if (AE && acr) m_acr = 1;
    if (fs) begin
      m_if[3] = 1;
      if (AE) m_if[4] = 1;
      if (m_fcnt == 0) m_if[5] = 1;
      m_fcnt = (m_fcnt + 1) % DIV;
    end
  endtask

  // Drives one clock of inputs, advances the model and records observed grants.
  task automatic cycle(input bit fs, input bit acr, input bit aud, input bit slot);
    frame_start = fs; acr_req = acr; audio_req = aud; slot_start = slot;
    @(posedge clk_pixel); #1;
    model_step(fs, acr, aud, slot);
    if (packet_grant === 1'b1) seen.push_back(packet_type);
    if (audio_ack === 1'b1) ack_seen++;
    frame_start = 0; acr_req = 0; slot_start = 0;
  endtask

  task automatic slot(input bit aud);
    cycle(0, 0, aud, 1);
    cycle(0, 0, aud, 0);
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      frame_start = 1'($urandom); acr_req = 1'($urandom);
      audio_req = 1'($urandom); slot_start = 1'($urandom);
      @(posedge clk_pixel); #1;
      compared++;
      if ({packet_type, packet_grant, audio_ack} !== 5'b0) begin
        mismatched++;
        $display("FAIL reset_hold cycle %0d: type=%0d grant=%b ack=%b, required all 0",
                 i, packet_type, packet_grant, audio_ack);
      end
    end
    frame_start = 0; acr_req = 0; audio_req = 0; slot_start = 0;
    @(posedge clk_pixel); #1;
    reset_n = 1;
    @(posedge clk_pixel); #1;
    frame_start = 0;
    slot_start = 1;
    @(posedge clk_pixel); #1;
    slot_start = 0;
    compared++;
    if (packet_type !== 3'd0 || packet_grant !== 1'b1 || audio_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_first_slot: type=%0d grant=%b ack=%b, required type=0 grant=1 ack=0",
               packet_type, packet_grant, audio_ack);
    end
    model_step(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_frame_sequence();
    logic [2:0] exp_a[4] = '{3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0] exp_b[3] = '{3'd3, 3'd4, 3'd0};
    seen.delete();
    cycle(1, 0, 0, 0);
    repeat (4) slot(0);
    compared++;
    if (seen.size() != 4) begin
      mismatched++;
      $display("FAIL frame0_count: got %0d grants, required 4", seen.size());
    end else foreach (exp_a[i]) begin
      compared++;
      if (seen[i] !== exp_a[i]) begin
        mismatched++;
        $display("FAIL frame0_slot%0d: type=%0d, required %0d", i, seen[i], exp_a[i]);
      end
    end
    seen.delete();
    cycle(1, 0, 0, 0);
    repeat (3) slot(0);
    compared++;
    if (seen.size() != 3) begin
      mismatched++;
      $display("FAIL frame1_count: got %0d grants, required 3", seen.size());
    end else foreach (exp_b[i]) begin
      compared++;
      if (seen[i] !== exp_b[i]) begin
        mismatched++;
        $display("FAIL frame1_slot%0d: type=%0d, required %0d", i, seen[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_s[6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
    seen.delete();
    ack_seen = 0;
    cycle(1, 0, 1, 0);
    repeat (6) slot(1);
    compared++;
    if (seen.size() != 6) begin
      mismatched++;
      $display("FAIL starve_count: got %0d grants, required 6", seen.size());
    end else foreach (exp_s[i]) begin
      compared++;
      if (seen[i] !== exp_s[i]) begin
        mismatched++;
        $display("FAIL starve_slot%0d: type=%0d, required %0d", i, seen[i], exp_s[i]);
      end
    end
    compared++;
    if (ack_seen != 5) begin
      mismatched++;
      $display("FAIL starve_acks: got %0d audio_ack pulses, required 5", ack_seen);
    end
    repeat (3) slot(0);
  endtask

  task automatic test_acr_priority();
    logic [2:0] exp_r[6] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1};
    seen.delete();
    cycle(0, 1, 1, 0);
    slot(1);
    slot(1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    slot(0);
    slot(0);
    cycle(0, 1, 0, 1);   // coincident request is not eligible in this slot
    cycle(0, 0, 0, 0);
    slot(0);
    compared++;
    if (seen.size() != 6) begin
      mismatched++;
      $display("FAIL acr_count: got %0d grants, required 6", seen.size());
    end else foreach (exp_r[i]) begin
      compared++;
      if (seen[i] !== exp_r[i]) begin
        mismatched++;
        $display("FAIL acr_slot%0d: type=%0d, required %0d", i, seen[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_set_clear_collision();
    logic [2:0] exp_c[6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    seen.delete();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);   // grants AVI
    cycle(1, 0, 0, 0);   // frame_start in the following cycle
    slot(0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);   // frame_start coincident with the AVI grant
    cycle(0, 0, 0, 0);
    slot(0);
    slot(0);
    slot(0);
    compared++;
    if (seen.size() != 6) begin
      mismatched++;
      $display("FAIL collide_count: got %0d grants, required 6", seen.size());
    end else foreach (exp_c[i]) begin
      compared++;
      if (seen[i] !== exp_c[i]) begin
        mismatched++;
        $display("FAIL collide_slot%0d: type=%0d, required %0d", i, seen[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid_operation();
    logic [2:0] exp_m[5] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd0};
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);   // ACR granted, packet_type becomes 1
    cycle(0, 1, 0, 0);
    #3 reset_n = 0;
    #1;
    model_reset();
    compared++;
    if ({packet_type, packet_grant, audio_ack} !== 5'b0) begin
      mismatched++;
      $display("FAIL async_reset: type=%0d grant=%b ack=%b, required all 0",
               packet_type, packet_grant, audio_ack);
    end
    @(posedge clk_pixel); #1;
    reset_n = 1;
    seen.delete();
    slot(0);
    cycle(1, 0, 0, 0);
    repeat (4) slot(0);
    compared++;
    if (seen.size() != 5) begin
      mismatched++;
      $display("FAIL postreset_count: got %0d grants, required 5", seen.size());
    end else foreach (exp_m[i]) begin
      compared++;
      if (seen[i] !== exp_m[i]) begin
        mismatched++;
        $display("FAIL postreset_slot%0d: type=%0d, required %0d", i, seen[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_random_traffic();
    int gap = 2;
    bit aud = 0;
    bit fs, acr, sl;
    for (int i = 0; i < 4000; i++) begin
      fs  = ($urandom_range(0, 99) < 2);
      acr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 10) aud = ~aud;
      sl  = (gap >= 2) && ($urandom_range(0, 99) < 40);
      gap = sl ? 1 : gap + 1;
      cycle(fs, acr, aud, sl);
      compared++;
      if (packet_type !== m_type || packet_grant !== m_grant || audio_ack !== m_ack) begin
        mismatched++;
        $display("FAIL random cycle %0d: type=%0d grant=%b ack=%b, required type=%0d grant=%b ack=%b",
                 i, packet_type, packet_grant, audio_ack, m_type, m_grant, m_ack);
      end
    end
  endtask

  initial begin
    reset_n = 0;
    frame_start = 0; acr_req = 0; audio_req = 0; slot_start = 0;
    ack_seen = 0;
    #1;
    test_reset();
    test_frame_sequence();
    test_starvation();
    test_acr_priority();
    test_set_clear_collision();
    test_reset_mid_operation();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
